// File: rtl/hnoc_leaf_switch.sv
// hnoc_leaf_switch: leaf router joining NumLocal PE ports and one uplink through
// per-input FIFOs, per-output round-robin arbiters and registered outputs.
// Define HNOC_STATS_EN to add the o_drop_count misroute counter port.
module hnoc_leaf_switch #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 3,
   parameter int unsigned NumLocal  = 4,
   parameter int unsigned LeafBase  = 0,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                                      i_clk,
   input  logic                                      i_reset,
   input  logic [NumLocal*(DataWidth+AddrWidth)-1:0] i_pe_data,
   input  logic [NumLocal-1:0]                       i_pe_data_valid,
   output logic [NumLocal-1:0]                       o_pe_data_ready,
   output logic [NumLocal*(DataWidth+AddrWidth)-1:0] o_pe_data,
   output logic [NumLocal-1:0]                       o_pe_data_valid,
   input  logic [NumLocal-1:0]                       i_pe_data_ready,
   input  logic [DataWidth+AddrWidth-1:0]            i_centre_data,
   input  logic                                      i_centre_data_valid,
   output logic                                      o_centre_data_ready,
   output logic [DataWidth+AddrWidth-1:0]            o_centre_data,
   output logic                                      o_centre_data_valid,
   input  logic                                      i_centre_data_ready
`ifdef HNOC_STATS_EN
   ,
   output logic [15:0]                               o_drop_count
`endif
);

   localparam int unsigned FW = DataWidth + AddrWidth;
   localparam int unsigned NP = NumLocal + 1;
   localparam int unsigned AW = $clog2(FifoDepth);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned LW = $clog2(NumLocal);
   localparam int unsigned RW = $clog2(NP);

   localparam logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(LeafBase);
   localparam logic [AddrWidth:0]   NumLocalW = (AddrWidth+1)'(NumLocal);
   localparam logic [RW-1:0]        UpIdx     = RW'(NumLocal);

   logic [FW-1:0]        in_data [NP];
   logic [NP-1:0]        in_valid;
   logic [NP-1:0]        out_ready;

   logic [FW-1:0]        fifo_mem_q [NP][FifoDepth];
   logic [FW-1:0]        fifo_mem_d [NP][FifoDepth];
   logic [PW-1:0]        wr_ptr_q [NP];
   logic [PW-1:0]        wr_ptr_d [NP];
   logic [PW-1:0]        rd_ptr_q [NP];
   logic [PW-1:0]        rd_ptr_d [NP];
   logic [NP-1:0]        fifo_full;
   logic [NP-1:0]        fifo_empty;
   logic [NP-1:0]        push;
   logic [NP-1:0]        pop;
   logic [NP-1:0]        drop;

   logic [FW-1:0]        head [NP];
   logic [AddrWidth-1:0] addr_off [NP];
   logic [NP-1:0]        local_hit;
   logic [RW-1:0]        dest [NP];
   logic [NP-1:0]        req [NP];

   logic [NP-1:0]        gnt_valid;
   logic [RW-1:0]        gnt_idx [NP];
   logic [RW-1:0]        rr_ptr_q [NP];
   logic [RW-1:0]        rr_ptr_d [NP];

   logic [FW-1:0]        out_data_q [NP];
   logic [FW-1:0]        out_data_d [NP];
   logic [NP-1:0]        out_valid_q;
   logic [NP-1:0]        out_valid_d;

   // Index NumLocal is the uplink on both the input and output side.
   always_comb begin
      for (int unsigned k = 0; k < NumLocal; k++) begin
         in_data[k] = i_pe_data[k*FW +: FW];
      end
      in_data[NumLocal] = i_centre_data;
      in_valid          = {i_centre_data_valid, i_pe_data_valid};
      out_ready         = {i_centre_data_ready, i_pe_data_ready};
   end

   // FIFO status and head routing. The offset compare relies on LeafBase
   // being NumLocal-aligned so the wrapped difference is a clean range test.
   always_comb begin
      for (int unsigned i = 0; i < NP; i++) begin
         fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         fifo_full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
         push[i]       = in_valid[i] && !fifo_full[i];
         head[i]       = fifo_mem_q[i][rd_ptr_q[i][AW-1:0]];
         addr_off[i]   = head[i][FW-1:DataWidth] - BaseAddr;
         local_hit[i]  = ({1'b0, addr_off[i]} < NumLocalW);
         dest[i]       = local_hit[i] ? RW'(addr_off[i][LW-1:0]) : UpIdx;
         drop[i]       = (i == NumLocal) && !fifo_empty[i] && !local_hit[i];
      end
   end

   always_comb begin
      for (int unsigned o = 0; o < NP; o++) begin
         for (int unsigned i = 0; i < NP; i++) begin
            req[o][i] = !fifo_empty[i] && !drop[i] && (dest[i] == RW'(o));
         end
      end
   end

   // Round-robin as two ordered passes: requesters at or above the pointer
   // first, then the lowest requester below it.
   always_comb begin
      for (int unsigned o = 0; o < NP; o++) begin
         gnt_valid[o] = 1'b0;
         gnt_idx[o]   = '0;
         rr_ptr_d[o]  = rr_ptr_q[o];
         if (!out_valid_q[o] || out_ready[o]) begin
            for (int unsigned i = 0; i < NP; i++) begin
               if (!gnt_valid[o] && req[o][i] && (RW'(i) >= rr_ptr_q[o])) begin
                  gnt_valid[o] = 1'b1;
                  gnt_idx[o]   = RW'(i);
               end
            end
            for (int unsigned i = 0; i < NP; i++) begin
               if (!gnt_valid[o] && req[o][i]) begin
                  gnt_valid[o] = 1'b1;
                  gnt_idx[o]   = RW'(i);
               end
            end
            if (gnt_valid[o]) begin
               rr_ptr_d[o] = (gnt_idx[o] == UpIdx) ? '0 : gnt_idx[o] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      pop = drop;
      for (int unsigned o = 0; o < NP; o++) begin
         for (int unsigned i = 0; i < NP; i++) begin
            if (gnt_valid[o] && (gnt_idx[o] == RW'(i))) begin
               pop[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      for (int unsigned i = 0; i < NP; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
         if (push[i]) begin
            fifo_mem_d[i][wr_ptr_q[i][AW-1:0]] = in_data[i];
         end
      end
   end

   always_comb begin
      for (int unsigned o = 0; o < NP; o++) begin
         out_data_d[o]  = out_data_q[o];
         out_valid_d[o] = out_valid_q[o] && !out_ready[o];
         if (gnt_valid[o]) begin
            out_data_d[o]  = head[gnt_idx[o]];
            out_valid_d[o] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int unsigned i = 0; i < NP; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            rr_ptr_q[i] <= '0;
         end
         out_valid_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NP; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            rr_ptr_q[i] <= rr_ptr_d[i];
         end
         out_valid_q <= out_valid_d;
      end
   end

   // Storage needs no reset: pointers and valids alone define occupancy.
   always_ff @(posedge i_clk) begin
      fifo_mem_q <= fifo_mem_d;
      out_data_q <= out_data_d;
   end

`ifdef HNOC_STATS_EN
   logic [15:0] drop_count_q;
   logic [15:0] drop_count_d;

   always_comb begin
      drop_count_d = drop_count_q;
      if (drop[NumLocal] && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         drop_count_q <= '0;
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign o_drop_count = drop_count_q;
`endif

   always_comb begin
      for (int unsigned k = 0; k < NumLocal; k++) begin
         o_pe_data[k*FW +: FW] = out_data_q[k];
      end
      o_pe_data_valid     = out_valid_q[NumLocal-1:0];
      o_pe_data_ready     = ~fifo_full[NumLocal-1:0];
      o_centre_data       = out_data_q[NumLocal];
      o_centre_data_valid = out_valid_q[NumLocal];
      o_centre_data_ready = ~fifo_full[NumLocal];
   end

endmodule

// File: tb/tb_hnoc_leaf_switch.sv
// Directed self-checking bench for hnoc_leaf_switch (NumLocal=4, LeafBase=4,
// AddrWidth=3, DataWidth=32, FifoDepth=4). Cycle 0 = cycle a flit is offered.
module tb_hnoc_leaf_switch;

   localparam int unsigned DW = 32;
   localparam int unsigned AWD = 3;
   localparam int unsigned NL = 4;
   localparam int unsigned FW = DW + AWD;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic [NL*FW-1:0]  i_pe_data;
   logic [NL-1:0]     i_pe_data_valid;
   logic [NL-1:0]     o_pe_data_ready;
   logic [NL*FW-1:0]  o_pe_data;
   logic [NL-1:0]     o_pe_data_valid;
   logic [NL-1:0]     i_pe_data_ready;
   logic [FW-1:0]     i_centre_data;
   logic              i_centre_data_valid;
   logic              o_centre_data_ready;
   logic [FW-1:0]     o_centre_data;
   logic              o_centre_data_valid;
   logic              i_centre_data_ready;
`ifdef HNOC_STATS_EN
   logic [15:0]       o_drop_count;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   hnoc_leaf_switch #(
      .DataWidth (DW),
      .AddrWidth (AWD),
      .NumLocal  (NL),
      .LeafBase  (4),
      .FifoDepth (4)
   ) dut (
      .i_clk               (i_clk),
      .i_reset             (i_reset),
      .i_pe_data           (i_pe_data),
      .i_pe_data_valid     (i_pe_data_valid),
      .o_pe_data_ready     (o_pe_data_ready),
      .o_pe_data           (o_pe_data),
      .o_pe_data_valid     (o_pe_data_valid),
      .i_pe_data_ready     (i_pe_data_ready),
      .i_centre_data       (i_centre_data),
      .i_centre_data_valid (i_centre_data_valid),
      .o_centre_data_ready (o_centre_data_ready),
      .o_centre_data       (o_centre_data),
      .o_centre_data_valid (o_centre_data_valid),
      .i_centre_data_ready (i_centre_data_ready)
`ifdef HNOC_STATS_EN
      ,
      .o_drop_count        (o_drop_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [FW-1:0] flit(input logic [2:0] a, input logic [31:0] d);
      return {a, d};
   endfunction

   function automatic logic [FW-1:0] pe_out(input int unsigned k);
      return o_pe_data[k*FW +: FW];
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_pe(input int unsigned k, input logic [2:0] a, input logic [31:0] d);
      i_pe_data[k*FW +: FW] = flit(a, d);
      i_pe_data_valid[k]    = 1'b1;
   endtask

   task automatic clr_pe(input int unsigned k);
      i_pe_data[k*FW +: FW] = '0;
      i_pe_data_valid[k]    = 1'b0;
   endtask

   initial begin
      i_reset             = 1'b1;
      i_pe_data           = '0;
      i_pe_data_valid     = '0;
      i_pe_data_ready     = '1;
      i_centre_data       = '0;
      i_centre_data_valid = 1'b0;
      i_centre_data_ready = 1'b1;
      repeat (3) step();
      i_reset = 1'b0;

      // Reset state
      check_eq("rst_pe_valid", 64'(o_pe_data_valid), 64'h0);
      check_eq("rst_up_valid", 64'(o_centre_data_valid), 64'h0);
      check_eq("rst_pe_ready", 64'(o_pe_data_ready), 64'hF);
      check_eq("rst_up_ready", 64'(o_centre_data_ready), 64'h1);
`ifdef HNOC_STATS_EN
      check_eq("rst_drops", 64'(o_drop_count), 64'h0);
`endif
      step();

      // Local to local: port 0 -> addr 6 -> port 2
      set_pe(0, 3'd6, 32'hDEADBEEF);
      check_eq("l2l_rdy", 64'(o_pe_data_ready[0]), 64'h1);
      step();
      clr_pe(0);
      check_eq("l2l_c1_valid", 64'(o_pe_data_valid), 64'h0);
      step();
      check_eq("l2l_c2_valid", 64'(o_pe_data_valid), 64'h4);
      check_eq("l2l_c2_data", 64'(pe_out(2)), 64'(flit(3'd6, 32'hDEADBEEF)));
      check_eq("l2l_c2_up", 64'(o_centre_data_valid), 64'h0);
      step();
      check_eq("l2l_c3_valid", 64'(o_pe_data_valid), 64'h0);

      // Local to uplink: port 1 -> addr 1
      set_pe(1, 3'd1, 32'h12345678);
      step();
      clr_pe(1);
      check_eq("l2u_c1_up", 64'(o_centre_data_valid), 64'h0);
      step();
      check_eq("l2u_c2_up", 64'(o_centre_data_valid), 64'h1);
      check_eq("l2u_c2_data", 64'(o_centre_data), 64'(flit(3'd1, 32'h12345678)));
      check_eq("l2u_c2_pe", 64'(o_pe_data_valid), 64'h0);
      step();
      check_eq("l2u_c3_up", 64'(o_centre_data_valid), 64'h0);

      // Contention: ports 0,1,3 -> addr 5 (port 1), granted 0,1,3
      set_pe(0, 3'd5, 32'hA0);
      set_pe(1, 3'd5, 32'hA1);
      set_pe(3, 3'd5, 32'hA3);
      step();
      clr_pe(0);
      clr_pe(1);
      clr_pe(3);
      step();
      check_eq("arb_c2_valid", 64'(o_pe_data_valid), 64'h2);
      check_eq("arb_c2_data", 64'(pe_out(1)), 64'(flit(3'd5, 32'hA0)));
      step();
      check_eq("arb_c3_valid", 64'(o_pe_data_valid), 64'h2);
      check_eq("arb_c3_data", 64'(pe_out(1)), 64'(flit(3'd5, 32'hA1)));
      step();
      check_eq("arb_c4_valid", 64'(o_pe_data_valid), 64'h2);
      check_eq("arb_c4_data", 64'(pe_out(1)), 64'(flit(3'd5, 32'hA3)));
      step();
      check_eq("arb_c5_valid", 64'(o_pe_data_valid), 64'h0);

      // Backpressure: port 2 sink stalled, port 0 streams 1..6 to addr 6
      i_pe_data_ready[2] = 1'b0;
      for (int unsigned d = 1; d <= 5; d++) begin
         set_pe(0, 3'd6, 32'(d));
         check_eq("bp_accept_rdy", 64'(o_pe_data_ready[0]), 64'h1);
         step();
      end
      set_pe(0, 3'd6, 32'd6);
      check_eq("bp_full_rdy", 64'(o_pe_data_ready[0]), 64'h0);
      check_eq("bp_hold_valid", 64'(o_pe_data_valid[2]), 64'h1);
      check_eq("bp_hold_data", 64'(pe_out(2)), 64'(flit(3'd6, 32'd1)));
      step();
      check_eq("bp_still_full", 64'(o_pe_data_ready[0]), 64'h0);
      i_pe_data_ready[2] = 1'b1;
      check_eq("bp_d1", 64'(pe_out(2)), 64'(flit(3'd6, 32'd1)));
      step();
      check_eq("bp_d2", 64'(pe_out(2)), 64'(flit(3'd6, 32'd2)));
      check_eq("bp_rdy_again", 64'(o_pe_data_ready[0]), 64'h1);
      step();
      clr_pe(0);
      for (int unsigned d = 3; d <= 6; d++) begin
         check_eq("bp_seq_valid", 64'(o_pe_data_valid), 64'h4);
         check_eq("bp_seq_data", 64'(pe_out(2)), 64'(flit(3'd6, 32'(d))));
         step();
      end
      check_eq("bp_drained", 64'(o_pe_data_valid), 64'h0);

      // Misroute: uplink -> addr 0 is dropped
      i_centre_data       = flit(3'd0, 32'h55);
      i_centre_data_valid = 1'b1;
      check_eq("mis_up_rdy", 64'(o_centre_data_ready), 64'h1);
      step();
      i_centre_data_valid = 1'b0;
      step();
      check_eq("mis_c2_pe", 64'(o_pe_data_valid), 64'h0);
      check_eq("mis_c2_up", 64'(o_centre_data_valid), 64'h0);
`ifdef HNOC_STATS_EN
      check_eq("mis_drops", 64'(o_drop_count), 64'h1);
`endif
      step();
      check_eq("mis_c3_pe", 64'(o_pe_data_valid), 64'h0);
      check_eq("mis_c3_up", 64'(o_centre_data_valid), 64'h0);

      // Uplink -> addr 7 -> port 3
      i_centre_data       = flit(3'd7, 32'h77);
      i_centre_data_valid = 1'b1;
      step();
      i_centre_data_valid = 1'b0;
      step();
      check_eq("u2l_valid", 64'(o_pe_data_valid), 64'h8);
      check_eq("u2l_data", 64'(pe_out(3)), 64'(flit(3'd7, 32'h77)));
      check_eq("u2l_up", 64'(o_centre_data_valid), 64'h0);
      step();

      // Loopback: port 3 -> addr 7 -> port 3
      set_pe(3, 3'd7, 32'hCAFE);
      step();
      clr_pe(3);
      step();
      check_eq("loop_valid", 64'(o_pe_data_valid), 64'h8);
      check_eq("loop_data", 64'(pe_out(3)), 64'(flit(3'd7, 32'hCAFE)));
      step();

      // Reset with three flits in flight
      i_pe_data_ready[2] = 1'b0;
      for (int unsigned d = 1; d <= 3; d++) begin
         set_pe(0, 3'd6, 32'hB0 + 32'(d));
         step();
      end
      clr_pe(0);
      check_eq("rmid_held", 64'(o_pe_data_valid[2]), 64'h1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      check_eq("rmid_pe_valid", 64'(o_pe_data_valid), 64'h0);
      check_eq("rmid_up_valid", 64'(o_centre_data_valid), 64'h0);
      check_eq("rmid_pe_ready", 64'(o_pe_data_ready), 64'hF);
      check_eq("rmid_up_ready", 64'(o_centre_data_ready), 64'h1);
`ifdef HNOC_STATS_EN
      check_eq("rmid_drops", 64'(o_drop_count), 64'h0);
`endif
      i_pe_data_ready[2] = 1'b1;
      for (int unsigned c = 0; c < 5; c++) begin
         step();
         check_eq("rmid_no_stale", 64'({o_centre_data_valid, o_pe_data_valid}), 64'h0);
      end

      // Post-reset operation: port 2 -> addr 4 -> port 0
      set_pe(2, 3'd4, 32'hC0);
      step();
      clr_pe(2);
      step();
      check_eq("post_valid", 64'(o_pe_data_valid), 64'h1);
      check_eq("post_data", 64'(pe_out(0)), 64'(flit(3'd4, 32'hC0)));
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
